// File: rtl/mac_tanh_pkg.sv
// Shared types, default parameters and derived-width helpers for mac_tanh_engine.
// Optional feature macro: TANH_INTERP_EN (linear interpolation between LUT entries).
package mac_tanh_pkg;

    // Default configuration
    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned ADDR_W_DEF   = 12;
    localparam int unsigned VEC_LEN_DEF  = 16;
    localparam int unsigned NUM_OUT_DEF  = 16;
    localparam int unsigned ACC_W_DEF    = 36;
    localparam int unsigned IDX_LSB_DEF  = 24;
    localparam int unsigned LUT_AW_DEF   = 9;
    localparam int unsigned X_BASE_DEF   = 0;
    localparam int unsigned OUT_BASE_DEF = 256;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MAC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_LUT0  = 3'd3,
        ST_LUT1  = 3'd4,
        ST_CALC  = 3'd5,
        ST_WR    = 3'd6
    } state_t;

    // Full-precision product width
    function automatic int unsigned prod_w(input int unsigned data_w);
        return 2 * data_w;
    endfunction

    // Number of LUT entries
    function automatic int unsigned lut_depth(input int unsigned lut_aw);
        return 1 << lut_aw;
    endfunction

    // Interpolation fraction width: everything below the LUT index
    function automatic int unsigned frac_w(input int unsigned idx_lsb);
        return idx_lsb;
    endfunction

    // Accumulator can hold VEC_LEN full products without overflow
    function automatic bit acc_w_ok(input int unsigned acc_w,
                                    input int unsigned data_w,
                                    input int unsigned vec_len);
        return acc_w >= (2 * data_w + $clog2(vec_len));
    endfunction

endpackage

// File: rtl/tanh_interp.sv
// Combinational tanh activation: abs, LUT index saturation, optional linear
// interpolation and sign restore. Optional feature macro: TANH_INTERP_EN.
module tanh_interp
    import mac_tanh_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned IDX_LSB = IDX_LSB_DEF,
    parameter int unsigned LUT_AW  = LUT_AW_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] l0,
`ifdef TANH_INTERP_EN
    input  logic [DATA_W-1:0] l1,
`endif
    output logic [LUT_AW-1:0] idx,
    output logic [DATA_W-1:0] y
);

    localparam int unsigned DEPTH = lut_depth(LUT_AW);

    logic              sgn;
    logic [ACC_W-1:0]  mag;
    logic [ACC_W-1:0]  idx_raw;
    logic              sat;
    logic [DATA_W-1:0] mag_y;

    // Sign/magnitude split; the most negative value maps to its unsigned magnitude
    always_comb begin
        sgn     = acc[ACC_W-1];
        mag     = sgn ? (~acc + ACC_W'(1)) : acc;
        idx_raw = mag >> IDX_LSB;
        sat     = (idx_raw >= ACC_W'(DEPTH - 1));
        idx     = sat ? LUT_AW'(DEPTH - 1) : LUT_AW'(idx_raw);
    end

`ifdef TANH_INTERP_EN
    localparam int unsigned FRAC_W = frac_w(IDX_LSB);
    localparam int unsigned MUL_W  = DATA_W + FRAC_W + 2;

    logic [FRAC_W-1:0]        frac;
    logic signed [DATA_W:0]   diff;
    logic signed [MUL_W-1:0]  step_full;

    // Linear interpolation between L0 and L1; fraction is zero once saturated
    always_comb begin
        frac      = sat ? '0 : mag[FRAC_W-1:0];
        diff      = $signed({1'b0, l1}) - $signed({1'b0, l0});
        step_full = MUL_W'(diff) * $signed(MUL_W'(frac));
        mag_y     = l0 + DATA_W'(step_full >>> IDX_LSB);
    end
`else
    // Nearest-lower LUT entry
    always_comb begin
        mag_y = l0;
    end
`endif

    // Restore sign (two's complement)
    always_comb begin
        y = sgn ? (~mag_y + DATA_W'(1)) : mag_y;
    end

endmodule

// File: rtl/mac_tanh_engine.sv
// Matrix-vector MAC engine with tanh activation; results written back to SRAM.
// Optional feature macro: TANH_INTERP_EN (adds LUT1 state and interpolation).
module mac_tanh_engine
    import mac_tanh_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned VEC_LEN  = VEC_LEN_DEF,
    parameter int unsigned NUM_OUT  = NUM_OUT_DEF,
    parameter int unsigned ACC_W    = ACC_W_DEF,
    parameter int unsigned IDX_LSB  = IDX_LSB_DEF,
    parameter int unsigned LUT_AW   = LUT_AW_DEF,
    parameter int unsigned X_BASE   = X_BASE_DEF,
    parameter int unsigned OUT_BASE = OUT_BASE_DEF
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              xxx__dut__run,
    output logic              dut__xxx__busy,
    output logic [ADDR_W-1:0] dut__sram__write_address,
    output logic [DATA_W-1:0] dut__sram__write_data,
    output logic              dut__sram__write_enable,
    output logic [ADDR_W-1:0] dut__sram__read_address,
    input  logic [DATA_W-1:0] sram__dut__read_data,
    output logic [ADDR_W-1:0] dut__gmem__read_address,
    input  logic [DATA_W-1:0] gmem__dut__read_data,
    output logic [LUT_AW-1:0] dut__tanhmem__read_address,
    input  logic [DATA_W-1:0] tanhmem__dut__read_data
);

    localparam int unsigned PROD_W = prod_w(DATA_W);
    localparam int unsigned K_W    = $clog2(VEC_LEN);
    localparam int unsigned ROW_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    // Elaboration guard: accumulator must be wide enough to never overflow
    if (!acc_w_ok(ACC_W, DATA_W, VEC_LEN)) begin : g_acc_w_too_narrow
        $error("mac_tanh_engine: ACC_W below 2*DATA_W+clog2(VEC_LEN)");
    end

    state_t            state, state_nxt;
    logic [K_W-1:0]    k, k_nxt;
    logic [ROW_W-1:0]  row, row_nxt;
    logic              drain2, drain2_nxt;

    logic              busy_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] waddr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [ADDR_W-1:0] sram_ra_nxt;
    logic [ADDR_W-1:0] gmem_ra_nxt;
    logic [LUT_AW-1:0] lut_ra_nxt;

    logic                     rd_vld, rd_first;
    logic                     prod_vld, prod_first;
    logic signed [PROD_W-1:0] prod;
    logic [ACC_W-1:0]         prod_ext;
    logic [ACC_W-1:0]         acc, acc_d;

    logic [LUT_AW-1:0] idx;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] l0_src;

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state                      <= ST_IDLE;
            k                          <= '0;
            row                        <= '0;
            drain2                     <= 1'b0;
            dut__xxx__busy             <= 1'b0;
            dut__sram__write_enable    <= 1'b0;
            dut__sram__write_address   <= '0;
            dut__sram__write_data      <= '0;
            dut__sram__read_address    <= '0;
            dut__gmem__read_address    <= '0;
            dut__tanhmem__read_address <= '0;
        end else begin
            state                      <= state_nxt;
            k                          <= k_nxt;
            row                        <= row_nxt;
            drain2                     <= drain2_nxt;
            dut__xxx__busy             <= busy_nxt;
            dut__sram__write_enable    <= we_nxt;
            dut__sram__write_address   <= waddr_nxt;
            dut__sram__write_data      <= wdata_nxt;
            dut__sram__read_address    <= sram_ra_nxt;
            dut__gmem__read_address    <= gmem_ra_nxt;
            dut__tanhmem__read_address <= lut_ra_nxt;
        end
    end

    // Next-state sequencing and next values of the registered outputs
    always_comb begin
        state_nxt   = state;
        k_nxt       = k;
        row_nxt     = row;
        drain2_nxt  = drain2;
        waddr_nxt   = dut__sram__write_address;
        wdata_nxt   = dut__sram__write_data;
        sram_ra_nxt = dut__sram__read_address;
        gmem_ra_nxt = dut__gmem__read_address;
        lut_ra_nxt  = dut__tanhmem__read_address;

        case (state)
            ST_IDLE: begin
                if (xxx__dut__run) begin
                    state_nxt = ST_MAC;
                    k_nxt     = '0;
                    row_nxt   = '0;
                end
            end
            ST_MAC: begin
                if (k == K_W'(VEC_LEN - 1)) begin
                    state_nxt  = ST_DRAIN;
                    drain2_nxt = 1'b0;
                end else begin
                    k_nxt = k + K_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain2) begin
                    state_nxt = ST_LUT0;
                end else begin
                    drain2_nxt = 1'b1;
                end
            end
            ST_LUT0: begin
`ifdef TANH_INTERP_EN
                state_nxt = ST_LUT1;
`else
                state_nxt = ST_CALC;
`endif
            end
            ST_LUT1: begin
                state_nxt = ST_CALC;
            end
            ST_CALC: begin
                state_nxt = ST_WR;
                waddr_nxt = ADDR_W'(OUT_BASE) + ADDR_W'(row);
                wdata_nxt = y;
            end
            ST_WR: begin
                if (row == ROW_W'(NUM_OUT - 1)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_MAC;
                    row_nxt   = row + ROW_W'(1);
                    k_nxt     = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Addresses are launched one cycle ahead so they are valid in the state itself
        if (state_nxt == ST_MAC) begin
            sram_ra_nxt = ADDR_W'(X_BASE) + ADDR_W'(k_nxt);
            gmem_ra_nxt = ADDR_W'(row_nxt) * ADDR_W'(VEC_LEN) + ADDR_W'(k_nxt);
        end
        if (state_nxt == ST_LUT0) begin
            lut_ra_nxt = idx;
        end
        if (state_nxt == ST_LUT1) begin
            lut_ra_nxt = idx + LUT_AW'(1);
        end

        busy_nxt = (state_nxt != ST_IDLE);
        we_nxt   = (state_nxt == ST_WR);
    end

    // Read-data valid tracking, product register and accumulator
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rd_vld     <= 1'b0;
            rd_first   <= 1'b0;
            prod_vld   <= 1'b0;
            prod_first <= 1'b0;
            prod       <= '0;
            acc        <= '0;
        end else begin
            rd_vld     <= (state == ST_MAC);
            rd_first   <= (state == ST_MAC) && (k == '0);
            prod_vld   <= rd_vld;
            prod_first <= rd_first;
            if (rd_vld) begin
                prod <= PROD_W'($signed(sram__dut__read_data)) *
                        PROD_W'($signed(gmem__dut__read_data));
            end
            acc <= acc_d;
        end
    end

    // Value acc takes at the next edge; lets the LUT0 address launch from the final sum
    always_comb begin
        prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        acc_d    = acc;
        if (prod_vld) begin
            acc_d = prod_first ? prod_ext : (acc + prod_ext);
        end
    end

`ifdef TANH_INTERP_EN
    logic [DATA_W-1:0] l0_q;

    // Lower LUT entry arrives during LUT1
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            l0_q <= '0;
        end else if (state == ST_LUT1) begin
            l0_q <= tanhmem__dut__read_data;
        end
    end

    // Interpolation uses the held L0 and the live L1
    always_comb begin
        l0_src = l0_q;
    end
`else
    // L0 is consumed directly from the LUT in CALC
    always_comb begin
        l0_src = tanhmem__dut__read_data;
    end
`endif

    tanh_interp #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .IDX_LSB (IDX_LSB),
        .LUT_AW  (LUT_AW)
    ) u_tanh_interp (
        .acc (acc_d),
        .l0  (l0_src),
`ifdef TANH_INTERP_EN
        .l1  (tanhmem__dut__read_data),
`endif
        .idx (idx),
        .y   (y)
    );

endmodule

// File: tb/tb_mac_tanh_engine.sv
// Scoreboard bench for mac_tanh_engine: VEC_LEN=4, NUM_OUT=2, LUT_AW=8.
module tb_mac_tanh_engine;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned VEC_LEN = 4;
    localparam int unsigned NUM_OUT = 2;
    localparam int unsigned LUT_AW  = 8;
`ifdef TANH_INTERP_EN
    localparam int ROW_LAT = VEC_LEN + 6;
    localparam bit INTERP  = 1'b1;
`else
    localparam int ROW_LAT = VEC_LEN + 5;
    localparam bit INTERP  = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_b;
    logic              run;
    logic              busy;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic [ADDR_W-1:0] sram_ra;
    logic [DATA_W-1:0] sram_rd;
    logic [ADDR_W-1:0] gmem_ra;
    logic [DATA_W-1:0] gmem_rd;
    logic [LUT_AW-1:0] lut_ra;
    logic [DATA_W-1:0] lut_rd;

    logic [DATA_W-1:0] sram_mem [0:4095];
    logic [DATA_W-1:0] gmem_mem [0:4095];
    logic [DATA_W-1:0] lut_mem  [0:255];

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  busy_cyc = 0;

    always #5 clk = ~clk;

    mac_tanh_engine #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .VEC_LEN (VEC_LEN),
        .NUM_OUT (NUM_OUT),
        .LUT_AW  (LUT_AW)
    ) dut (
        .clk                        (clk),
        .reset_b                    (reset_b),
        .xxx__dut__run              (run),
        .dut__xxx__busy             (busy),
        .dut__sram__write_address   (waddr),
        .dut__sram__write_data      (wdata),
        .dut__sram__write_enable    (we),
        .dut__sram__read_address    (sram_ra),
        .sram__dut__read_data       (sram_rd),
        .dut__gmem__read_address    (gmem_ra),
        .gmem__dut__read_data       (gmem_rd),
        .dut__tanhmem__read_address (lut_ra),
        .tanhmem__dut__read_data    (lut_rd)
    );

    // One-cycle-latency memory models
    always @(posedge clk) begin
        sram_rd <= sram_mem[sram_ra];
        gmem_rd <= gmem_mem[gmem_ra];
        lut_rd  <= lut_mem[lut_ra];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: busy-cycle counter and write checking against the scoreboard
    always @(negedge clk) begin
        if (busy) busy_cyc = busy_cyc + 1;
        else      busy_cyc = 0;
        if (we) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected", waddr, wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(waddr), 32'(e.addr));
                check("wr_data", 32'(wdata), 32'(e.data));
                check("wr_latency", 32'(busy_cyc), 32'(e.cyc));
            end
        end
    end

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int c);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [DATA_W-1:0] xv, input logic [DATA_W-1:0] g0,
                        input logic [DATA_W-1:0] g1);
        for (int k = 0; k < int'(VEC_LEN); k++) begin
            sram_mem[k]                = xv;
            gmem_mem[k]                = g0;
            gmem_mem[int'(VEC_LEN)+k]  = g1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse run, count busy cycles; optionally re-pulse run while busy
    task automatic run_and_count(input bit poke);
        int n;
        tick();
        run = 1'b1;
        tick();
        run = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            run = poke && (n == 3 || n == ROW_LAT + 2 || n == 2 * ROW_LAT);
            tick();
        end
        run = 1'b0;
        check("busy_cycles", 32'(n), 32'(2 * ROW_LAT));
        repeat (3) tick();
        check("idle_after_run", 32'(busy), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_vec(input logic [DATA_W-1:0] xv, input logic [DATA_W-1:0] g0,
                           input logic [DATA_W-1:0] g1, input logic [DATA_W-1:0] e0,
                           input logic [DATA_W-1:0] e1);
        load(xv, g0, g1);
        push(12'd256, e0, ROW_LAT);
        push(12'd257, e1, 2 * ROW_LAT);
        run_and_count(1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            sram_mem[i] = '0;
            gmem_mem[i] = '0;
        end
        for (int i = 0; i < 256; i++) lut_mem[i] = 16'(i * 64);

        reset_b = 1'b0;
        run     = 1'b0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(we), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);
        check("rst_wdata", 32'(wdata), 32'd0);
        check("rst_sram_ra", 32'(sram_ra), 32'd0);
        check("rst_gmem_ra", 32'(gmem_ra), 32'd0);
        check("rst_lut_ra", 32'(lut_ra), 32'd0);
        reset_b = 1'b1;
        tick();

        // Basic positive / negative rows
        run_vec(16'h4000, 16'h1000, 16'hF000, 16'h0400, 16'hFC00);
        // Half-step interpolation, positive and negative
        run_vec(16'h4000, 16'h1080, 16'hEF80,
                INTERP ? 16'h0420 : 16'h0400, INTERP ? 16'hFBE0 : 16'hFC00);
        // Saturation at LUT top, both signs
        run_vec(16'h7FFF, 16'h7FFF, 16'h8000, 16'h3FC0, 16'hC040);
        run_vec(16'h8000, 16'h8000, 16'h7FFF, 16'h3FC0, 16'hC040);
        // Quarter-step interpolation and zero result
        run_vec(16'h4000, 16'h1040, 16'h0000, INTERP ? 16'h0410 : 16'h0400, 16'h0000);

        // Run re-pulsed mid-run and on the final WR cycle: ignored
        load(16'h4000, 16'h1000, 16'hF000);
        push(12'd256, 16'h0400, ROW_LAT);
        push(12'd257, 16'hFC00, 2 * ROW_LAT);
        run_and_count(1'b1);

        // Reset during row1 MAC: only the row0 write may appear
        push(12'd256, 16'h0400, ROW_LAT);
        tick();
        run = 1'b1;
        tick();
        run = 1'b0;
        repeat (ROW_LAT + 1) tick();
        check("busy_before_reset", 32'(busy), 32'd1);
        reset_b = 1'b0;
        #1;
        check("busy_in_reset", 32'(busy), 32'd0);
        check("we_in_reset", 32'(we), 32'd0);
        tick();
        reset_b = 1'b1;
        repeat (2 * ROW_LAT + 5) tick();
        check("busy_after_reset", 32'(busy), 32'd0);
        check("reset_queue_drained", 32'(exp_q.size()), 32'd0);

        // Fresh run after reset
        run_vec(16'h4000, 16'h1000, 16'hF000, 16'h0400, 16'hFC00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
